// File: rtl/nasti_ram_sram_if.sv
// NASTI (AXI4-style) channel bundle: AW/W/B/AR/R signals with slave and master views.
interface nasti_channel #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 128,
   parameter int USER_WIDTH = 1
);
   logic [ID_WIDTH-1:0]     aw_id;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [7:0]              aw_len;
   logic [2:0]              aw_size;
   logic [1:0]              aw_burst;
   logic [USER_WIDTH-1:0]   aw_user;
   logic                    aw_valid;
   logic                    aw_ready;

   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_last;
   logic [USER_WIDTH-1:0]   w_user;
   logic                    w_valid;
   logic                    w_ready;

   logic [ID_WIDTH-1:0]     b_id;
   logic [1:0]              b_resp;
   logic [USER_WIDTH-1:0]   b_user;
   logic                    b_valid;
   logic                    b_ready;

   logic [ID_WIDTH-1:0]     ar_id;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic [7:0]              ar_len;
   logic [2:0]              ar_size;
   logic [1:0]              ar_burst;
   logic [USER_WIDTH-1:0]   ar_user;
   logic                    ar_valid;
   logic                    ar_ready;

   logic [ID_WIDTH-1:0]     r_id;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;
   logic                    r_last;
   logic [USER_WIDTH-1:0]   r_user;
   logic                    r_valid;
   logic                    r_ready;

   modport slave (
      input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
      output aw_ready,
      input  w_data, w_strb, w_last, w_user, w_valid,
      output w_ready,
      output b_id, b_resp, b_user, b_valid,
      input  b_ready,
      input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
      output ar_ready,
      output r_id, r_data, r_resp, r_last, r_user, r_valid,
      input  r_ready
   );

   modport master (
      output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid,
      input  aw_ready,
      output w_data, w_strb, w_last, w_user, w_valid,
      input  w_ready,
      input  b_id, b_resp, b_user, b_valid,
      output b_ready,
      output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid,
      input  ar_ready,
      input  r_id, r_data, r_resp, r_last, r_user, r_valid,
      output r_ready
   );
endinterface

// File: rtl/nasti_ram_sram.sv
// NASTI slave backed by a single-port synchronous RAM, one burst in flight at a time.
// Optional NASTI_RAM_BOUNDS_CHECK_EN: out-of-range beats are suppressed and answered with DECERR.
module nasti_ram_sram #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 128,
   parameter int USER_WIDTH = 1,
   parameter int MEM_DEPTH  = 1024
)(
   input logic         clk,
   input logic         rst,
   nasti_channel.slave nasti
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFF    = $clog2(STRB_W);
   localparam int IDXW   = $clog2(MEM_DEPTH);

   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, WRESP = 2'd2, READ = 2'd3} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_wr_prio;
   logic [ID_WIDTH-1:0]     r_txn_id;
   logic [USER_WIDTH-1:0]   r_txn_user;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]              r_txn_len;
   logic [2:0]              r_txn_size;
   logic [1:0]              r_txn_burst;
   logic [8:0]              r_cnt;
   logic                    r_err;
   logic                    r_dec;
   logic                    r_rvalid;
   logic                    r_rlast;
   logic [1:0]              r_rresp;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

   logic                    w_aw_ready;
   logic                    w_ar_ready;
   logic                    w_w_ready;
   logic                    w_b_valid;
   logic                    w_issue;
   logic                    w_aw_hs;
   logic                    w_ar_hs;
   logic                    w_w_hs;
   logic                    w_r_hs;
   logic                    w_oob;
   logic [IDXW-1:0]         w_idx;
   logic [ADDR_WIDTH-1:0]   w_next_addr;
   logic                    w_unused;

   // Beat-to-beat address step; WRAP stays inside the aligned (len+1)<<size window.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [2:0]            size,
      input logic [1:0]            burst,
      input logic [7:0]            len
   );
      logic [ADDR_WIDTH-1:0] incr;
      logic [ADDR_WIDTH-1:0] mask;
      incr = addr + (ADDR_WIDTH'(1) << size);
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b00:   next_addr = addr;
         2'b10:   next_addr = (addr & ~mask) | (incr & mask);
         default: next_addr = incr;
      endcase
   endfunction

   assign w_idx       = IDXW'(r_addr >> OFF);
   assign w_next_addr = next_addr(r_addr, r_txn_size, r_txn_burst, r_txn_len);
   assign w_unused    = ^nasti.w_user;

`ifdef NASTI_RAM_BOUNDS_CHECK_EN
   localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(STRB_W);
   assign w_oob = (64'(r_addr) >= MEM_BYTES);
`else
   assign w_oob = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_aw_ready  = 1'b0;
      w_ar_ready  = 1'b0;
      w_w_ready   = 1'b0;
      w_b_valid   = 1'b0;
      w_issue     = 1'b0;
      case (r_state)
         IDLE: begin
            w_aw_ready = !rst && (r_wr_prio || !nasti.ar_valid);
            w_ar_ready = !rst && (!r_wr_prio || !nasti.aw_valid);
            if (nasti.aw_valid && w_aw_ready) begin
               w_state_nxt = WRITE;
            end else if (nasti.ar_valid && w_ar_ready) begin
               w_state_nxt = READ;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         WRITE: begin
            w_w_ready = 1'b1;
            if (nasti.w_valid && (r_cnt[7:0] == r_txn_len)) begin
               w_state_nxt = WRESP;
            end else begin
               w_state_nxt = WRITE;
            end
         end
         WRESP: begin
            w_b_valid = 1'b1;
            if (nasti.b_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = WRESP;
            end
         end
         READ: begin
            // Next array read only when the output register is free or being drained.
            w_issue = (r_cnt <= {1'b0, r_txn_len}) && (!r_rvalid || nasti.r_ready);
            if (r_rvalid && nasti.r_ready && r_rlast) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = READ;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_aw_hs = nasti.aw_valid && w_aw_ready;
   assign w_ar_hs = nasti.ar_valid && w_ar_ready && !w_aw_hs;
   assign w_w_hs  = nasti.w_valid && w_w_ready;
   assign w_r_hs  = r_rvalid && nasti.r_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_wr_prio   <= 1'b1;
         r_txn_id    <= '0;
         r_txn_user  <= '0;
         r_addr      <= '0;
         r_txn_len   <= 8'd0;
         r_txn_size  <= 3'd0;
         r_txn_burst <= 2'd0;
         r_cnt       <= 9'd0;
         r_err       <= 1'b0;
         r_dec       <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rlast     <= 1'b0;
         r_rresp     <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         if (w_aw_hs) begin
            r_txn_id    <= nasti.aw_id;
            r_txn_user  <= nasti.aw_user;
            r_addr      <= nasti.aw_addr;
            r_txn_len   <= nasti.aw_len;
            r_txn_size  <= nasti.aw_size;
            r_txn_burst <= nasti.aw_burst;
            r_cnt       <= 9'd0;
            r_err       <= 1'b0;
            r_dec       <= 1'b0;
            r_wr_prio   <= !r_wr_prio;
         end else if (w_ar_hs) begin
            r_txn_id    <= nasti.ar_id;
            r_txn_user  <= nasti.ar_user;
            r_addr      <= nasti.ar_addr;
            r_txn_len   <= nasti.ar_len;
            r_txn_size  <= nasti.ar_size;
            r_txn_burst <= nasti.ar_burst;
            r_cnt       <= 9'd0;
            r_wr_prio   <= !r_wr_prio;
         end
         if (w_w_hs) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 9'd1;
            if (nasti.w_last != (r_cnt[7:0] == r_txn_len)) begin
               r_err <= 1'b1;
            end
            if (w_oob) begin
               r_dec <= 1'b1;
            end
         end
         if (w_issue) begin
            r_addr   <= w_next_addr;
            r_cnt    <= r_cnt + 9'd1;
            r_rvalid <= 1'b1;
            r_rlast  <= (r_cnt[7:0] == r_txn_len);
            r_rresp  <= w_oob ? 2'b11 : 2'b00;
         end else if (w_r_hs) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

   // Storage and its read register carry no reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (w_w_hs && !w_oob) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (nasti.w_strb[b]) begin
               r_mem[w_idx][b*8 +: 8] <= nasti.w_data[b*8 +: 8];
            end
         end
      end
      if (w_issue) begin
         r_rdata <= w_oob ? '0 : r_mem[w_idx];
      end
   end

   assign nasti.aw_ready = w_aw_ready;
   assign nasti.ar_ready = w_ar_ready;
   assign nasti.w_ready  = w_w_ready;
   assign nasti.b_valid  = w_b_valid;
   assign nasti.b_id     = r_txn_id;
   assign nasti.b_user   = r_txn_user;
   assign nasti.b_resp   = r_dec ? 2'b11 : (r_err ? 2'b10 : 2'b00);
   assign nasti.r_valid  = r_rvalid;
   assign nasti.r_last   = r_rlast;
   assign nasti.r_resp   = r_rresp;
   assign nasti.r_data   = r_rdata;
   assign nasti.r_id     = r_txn_id;
   assign nasti.r_user   = r_txn_user;
endmodule

// File: doc/nasti_ram_sram.md
NASTI_RAM_SRAM -- requirements
Module: nasti_ram_sram

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, width of all ID fields.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 128, data width; 8..256, power of two.
REQ-004 SHALL have parameter USER_WIDTH, default 1, width of all USER fields.
REQ-005 SHALL have parameter MEM_DEPTH, default 1024, storage size in DATA_WIDTH words, power of two.
REQ-006 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port nasti  nasti_channel.slave  parametrised  AW/W/B/AR/R channels.

Function
REQ-009 SHALL hold storage in an internal synchronous single-port array of MEM_DEPTH words; no DPI calls.
REQ-010 SHALL implement FSM IDLE, WRITE, WRESP, READ; one transaction in flight at a time.
REQ-011 SHALL, in IDLE, drive aw_ready = wr_prio | !ar_valid and ar_ready = !wr_prio | !aw_valid; both 0 in all other states.
REQ-012 SHALL toggle wr_prio after every accepted AW or AR; wr_prio = 1 (write first) after reset.
REQ-013 SHALL, on AW handshake, latch id/addr/len/size/burst/user and go to WRITE; on AR handshake, latch and go to READ.
REQ-014 SHALL compute beat addresses: FIXED holds address; INCR adds 1<<size bytes per beat; WRAP adds 1<<size and wraps within an aligned (len+1)<<size byte window; burst code 3 treated as INCR.
REQ-015 SHALL select word index = byte_addr >> log2(DATA_WIDTH/8), modulo MEM_DEPTH.
REQ-016 SHALL, in WRITE, drive w_ready = 1 and on each W handshake write bytes whose w_strb bit is 1, leaving other bytes unchanged.
REQ-017 SHALL end the write burst after len+1 W beats regardless of w_last; a w_last value mismatching beat position sets an error flag giving b_resp = SLVERR (2'b10).
REQ-018 SHALL, in WRESP, drive b_valid = 1 with latched b_id/b_user, hold all B fields stable until b_ready, then return to IDLE.
REQ-019 SHALL, in READ, issue one array read per beat; r_valid rises 1 cycle after first issue (1-cycle read latency).
REQ-020 SHALL sustain one R beat per cycle while r_ready = 1 and hold r_data/r_id/r_resp/r_last/r_user stable while r_valid & !r_ready.
REQ-021 SHALL assert r_last on beat len+1 only, and return to IDLE on that beat's handshake.
REQ-022 SHALL return r_resp/b_resp = OKAY (2'b00) unless REQ-017 or REQ-027 applies.
REQ-023 SHALL give len = 0 bursts single-beat behaviour with r_last = 1 / one W beat.

Reset
REQ-024 SHALL on rst = 1 immediately force state IDLE, wr_prio = 1, aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last = 0, error flag clear.
REQ-025 SHALL abandon any in-flight burst at reset without completing or responding; array contents are not reset and retain prior values.
REQ-026 SHALL resume normal operation on the first rising clk after rst deasserts.

Configuration
REQ-027 SHALL, with NASTI_RAM_BOUNDS_CHECK_EN defined, flag any beat whose byte address >= MEM_DEPTH*DATA_WIDTH/8: suppress that write, return zero read data, and give DECERR (2'b11) for that R beat / the whole B response.
REQ-028 SHALL, without NASTI_RAM_BOUNDS_CHECK_EN, wrap out-of-range addresses modulo MEM_DEPTH per REQ-015 and always respond per REQ-022.

Verification
REQ-029 SHALL cover: INCR write addr 0x40, len 3, size 4, strb all 1, data 1..4 -> B OKAY; INCR read same -> R 1,2,3,4, r_last on beat 4 only.
REQ-030 SHALL cover: WRAP read addr 0x70, len 3, size 4 (after REQ-029 data) -> word order 4,1,2,3.
REQ-031 SHALL cover: write strb 16'h00FF data all 0xFF over word of 0 -> read returns lower 8 bytes 0xFF, upper 8 bytes 0x00.
REQ-032 SHALL cover: aw_valid and ar_valid asserted together from reset -> AW accepted first, AR accepted after B handshake; r_ready toggled 1/0 -> R fields stable when stalled.
REQ-033 SHALL cover: read at addr MEM_DEPTH*16 with NASTI_RAM_BOUNDS_CHECK_EN -> r_resp 2'b11, data 0; without -> data of word 0, OKAY.
REQ-034 SHALL cover: rst pulsed mid-read beat 2 of len 7 -> r_valid 0 same cycle, IDLE, next AR serviced normally.
